hdbn_line_encoder: RTL and testbench

//  Full parametrised HDBn line encoder, successor to the fixed HDB3 V-insertion stage.

---
 rtl/hdbn_line_encoder_pkg.sv | 12 +
 rtl/hdbn_line_encoder_v_insert.sv | 23 ++
 rtl/hdbn_line_encoder.sv | 69 ++++++
 tb/tb_hdbn_line_encoder.sv | 102 ++++++++++
 4 files changed

// File: rtl/hdbn_line_encoder_pkg.sv
// hdbn_line_encoder_pkg: shared internal symbol codes and ternary output codes for the HDBn encoder
package hdbn_line_encoder_pkg;
  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_ONE  = 2'b01,
    SYM_V    = 2'b10,
    SYM_B    = 2'b11
  } sym_t;
  localparam logic [1:0] TERN_POS = 2'b01;
  localparam logic [1:0] TERN_NEG = 2'b11;
  localparam logic [1:0] TERN_NUL = 2'b00;
endpackage

// File: rtl/hdbn_line_encoder_v_insert.sv
// hdbn_v_insert: zero-run counter that marks the (ZMAX+1)th consecutive zero as a V symbol
module hdbn_v_insert
  import hdbn_line_encoder_pkg::*;
#(
  parameter int ZMAX  = 3,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic data,
  input  logic ami_mode,
  output sym_t sym
);
  logic [CNT_W-1:0] cnt;
  logic run_full;
  assign run_full = (cnt == CNT_W'(ZMAX));
  assign sym = data ? SYM_ONE : (!ami_mode && run_full) ? SYM_V : SYM_ZERO;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (valid) cnt <= (data || ami_mode || run_full) ? '0 : cnt + CNT_W'(1);
  end
endmodule

// File: rtl/hdbn_line_encoder.sv
// hdbn_line_encoder: NRZ to HDBn ternary line code (V insertion, B back-insertion, AMI polarity)
module hdbn_line_encoder
  import hdbn_line_encoder_pkg::*;
#(
  parameter int ZMAX  = 3,
  parameter int CNT_W = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_data,
  input  logic       i_ami_mode,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic       o_pos,
  output logic       o_neg,
  output logic       o_sub
);
  sym_t       sym_in;
  sym_t       sr [ZMAX+1];
  logic [ZMAX:0] srv;
  logic       par_odd;
  logic       last_pos;
  sym_t       tail;
  logic       pulse;
  logic [1:0] code_nxt;
  logic       last_nxt;
  hdbn_v_insert #(.ZMAX(ZMAX), .CNT_W(CNT_W)) u_v_insert (
    .clk      (i_clk),
    .rst      (i_rst),
    .valid    (i_valid),
    .data     (i_data),
    .ami_mode (i_ami_mode),
    .sym      (sym_in)
  );
  assign tail = sr[ZMAX];
  always_comb begin
    pulse    = (tail == SYM_ONE) || (tail == SYM_B);
    code_nxt = pulse ? (last_pos ? TERN_NEG : TERN_POS)
             : (tail == SYM_V) ? (last_pos ? TERN_POS : TERN_NEG) : TERN_NUL;
    last_nxt = pulse ? ~last_pos : last_pos;
  end
  // A V entering the head lines up with the first zero of its run entering the tail slot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i <= ZMAX; i++) sr[i] <= SYM_ZERO;
      srv      <= '0;
      par_odd  <= 1'b0;
      last_pos <= 1'b0;
      o_valid  <= 1'b0;
      o_code   <= TERN_NUL;
      o_sub    <= 1'b0;
    end else if (i_valid) begin
      sr[0] <= sym_in;
      for (int i = 1; i < ZMAX; i++) sr[i] <= sr[i-1];
      sr[ZMAX] <= (sym_in == SYM_V && !par_odd) ? SYM_B : sr[ZMAX-1];
      srv      <= {srv[ZMAX-1:0], 1'b1};
      par_odd  <= (sym_in == SYM_V) ? 1'b0 : (sym_in == SYM_ONE) ? ~par_odd : par_odd;
      last_pos <= last_nxt;
      o_valid  <= srv[ZMAX];
      o_code   <= code_nxt;
      o_sub    <= srv[ZMAX] && (tail == SYM_V);
    end else begin
      o_valid <= 1'b0;
    end
  end
  assign o_pos = (o_code == TERN_POS);
  assign o_neg = (o_code == TERN_NEG);
endmodule

// File: tb/tb_hdbn_line_encoder.sv
// tb_hdbn_line_encoder: directed HDB3 vectors with hand-computed ternary symbols
module tb_hdbn_line_encoder;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b11;
  localparam logic [1:0] Z = 2'b00;
  logic clk = 0, rst = 0, vin = 0, din = 0, ami = 0;
  logic o_valid, o_pos, o_neg, o_sub;
  logic [1:0] o_code;
  int checks = 0, errors = 0;
  logic bq[$];
  logic [1:0] cq[$];
  logic sq[$];
  hdbn_line_encoder dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .i_data(din), .i_ami_mode(ami),
    .o_valid(o_valid), .o_code(o_code), .o_pos(o_pos), .o_neg(o_neg), .o_sub(o_sub)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic send(input logic d, input logic m, input logic v);
    @(negedge clk);
    vin = v; din = d; ami = m;
    @(posedge clk);
    #1 vin = 0;
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1;
    #1;
    chk({tag, " rst valid"}, {1'b0, o_valid}, 2'b00);
    chk({tag, " rst code"}, o_code, Z);
    chk({tag, " rst rails"}, {o_pos, o_neg}, 2'b00);
    chk({tag, " rst sub"}, {1'b0, o_sub}, 2'b00);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic run(input string tag, input logic m, input int bub_at);
    int n;
    logic [1:0] held;
    n = bq.size();
    for (int i = 0; i < n + 4; i++) begin
      send(i < n ? bq[i] : 1'b1, m, 1'b1);
      if (i < 4) chk($sformatf("%s fill%0d valid", tag, i), {1'b0, o_valid}, 2'b00);
      else begin
        chk($sformatf("%s sym%0d valid", tag, i-4), {1'b0, o_valid}, 2'b01);
        chk($sformatf("%s sym%0d code", tag, i-4), o_code, cq[i-4]);
        chk($sformatf("%s sym%0d rails", tag, i-4), {o_pos, o_neg}, {cq[i-4] == P, cq[i-4] == N});
        chk($sformatf("%s sym%0d sub", tag, i-4), {1'b0, o_sub}, {1'b0, sq[i-4]});
      end
      if (i == bub_at) repeat (3) begin
        held = o_code;
        send(1'b0, m, 1'b0);
        chk({tag, " bubble valid"}, {1'b0, o_valid}, 2'b00);
        chk({tag, " bubble hold"}, o_code, held);
      end
    end
  endtask
  initial begin
    do_reset("t1");
    bq = '{1, 0, 0, 0, 0}; cq = '{P, Z, Z, Z, P}; sq = '{0, 0, 0, 0, 1};
    run("t1", 1'b0, -1);
    do_reset("t2");
    bq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    cq = '{P, Z, Z, P, N, Z, Z, N, P, Z, Z, P, N, Z, Z, N};
    sq = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    run("t2", 1'b0, -1);
    do_reset("t3");
    bq = '{1, 1, 0, 0, 0, 0}; cq = '{P, N, P, Z, Z, P}; sq = '{0, 0, 0, 0, 0, 1};
    run("t3", 1'b0, -1);
    do_reset("t4");
    bq = '{1, 0, 0, 0, 1}; cq = '{P, Z, Z, Z, N}; sq = '{0, 0, 0, 0, 0};
    run("t4", 1'b0, -1);
    do_reset("t5");
    bq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    cq = '{Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, P};
    sq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("t5", 1'b1, -1);
    do_reset("t6");
    bq = '{1, 0, 0, 0, 0}; cq = '{P, Z, Z, Z, P}; sq = '{0, 0, 0, 0, 1};
    run("t6", 1'b0, 2);
    do_reset("t7");
    repeat (6) send(1'b1, 1'b0, 1'b1);
    chk("t7 pre valid", {1'b0, o_valid}, 2'b01);
    chk("t7 pre code", o_code, N);
    #2 rst = 1;
    #1;
    chk("t7 mid valid", {1'b0, o_valid}, 2'b00);
    chk("t7 mid code", o_code, Z);
    chk("t7 mid rails", {o_pos, o_neg}, 2'b00);
    @(negedge clk);
    rst = 0;
    bq = '{0, 0, 0, 0}; cq = '{P, Z, Z, P}; sq = '{0, 0, 0, 1};
    run("t7", 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
